// File: rtl/instr_pkg.sv
// Shared instruction-word definitions for the fetch path: widths, field positions,
// reserved words and the pre-split field bundle handed to the decoder.
package instr_pkg;

   localparam int unsigned INSTR_W    = 9;
   localparam int unsigned FORMAT_BIT = 8;
   localparam int unsigned OPC_MSB    = 7;
   localparam int unsigned OPC_LSB    = 4;
   localparam int unsigned SIGN_BIT   = 3;
   localparam int unsigned OPER_MSB   = 2;
   localparam int unsigned OPER_LSB   = 0;
   localparam int unsigned IMM_MSB    = 7;
   localparam int unsigned IMM_LSB    = 0;

   localparam logic [INSTR_W-1:0] NOP_WORD       = 9'h000;
   localparam logic [INSTR_W-1:0] HALT_WORD_DFLT = 9'h1B0;

   typedef struct packed {
      logic       format;
      logic [3:0] opcode;
      logic       sign;
      logic [2:0] operand;
      logic [7:0] immediate;
   } instr_fields_t;

   function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] word);
      instr_fields_t f;
      f.format    = word[FORMAT_BIT];
      f.opcode    = word[OPC_MSB:OPC_LSB];
      f.sign      = word[SIGN_BIT];
      f.operand   = word[OPER_MSB:OPER_LSB];
      f.immediate = word[IMM_MSB:IMM_LSB];
      return f;
   endfunction

endpackage

// File: rtl/instr_bank_ram.sv
// Banked 1R1W instruction array: synchronous write, registered read (read-before-write),
// plus a registered flag telling whether the last read word equals MATCH_WORD.
module instr_bank_ram
   import instr_pkg::*;
#(
   parameter int unsigned            DEPTH      = 256,
   parameter int unsigned            BANKS      = 4,
   parameter logic [INSTR_W-1:0]     MATCH_WORD = HALT_WORD_DFLT,
   localparam int unsigned           AW         = $clog2(DEPTH),
   localparam int unsigned           BW         = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_we,
   input  logic [BW-1:0]      i_wbank,
   input  logic [AW-1:0]      i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic               i_re,
   input  logic [BW-1:0]      i_rbank,
   input  logic [AW-1:0]      i_raddr,
   input  logic               i_rzero,
   input  logic               i_hit_clr,
   output logic [INSTR_W-1:0] o_rdata,
   output logic               o_hit
);

   logic [INSTR_W-1:0] r_mem [BANKS][DEPTH];
   logic [INSTR_W-1:0] r_rdata;
   logic               r_hit;
   logic [INSTR_W-1:0] w_rword;

   // Array contents survive reset; only the read port register is cleared.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wbank][i_waddr] <= i_wdata;
      end
   end

   assign w_rword = i_rzero ? NOP_WORD : r_mem[i_rbank][i_raddr];

   // A new read overrides a pending clear so the delivered word's match status wins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rdata <= NOP_WORD;
         r_hit   <= 1'b0;
      end else if (i_re) begin
         r_rdata <= w_rword;
         r_hit   <= (w_rword == MATCH_WORD);
      end else if (i_hit_clr) begin
         r_hit   <= 1'b0;
      end
   end

   assign o_rdata = r_rdata;
   assign o_hit   = r_hit;

endmodule

// File: rtl/instr_fetch_rom.sv
// Loadable banked instruction store with a one-cycle valid/ready fetch port,
// pre-split instruction fields and sticky fault/halt status.
module instr_fetch_rom
   import instr_pkg::*;
#(
   parameter int unsigned        DEPTH     = 256,
   parameter int unsigned        BANKS     = 4,
   parameter int unsigned        PC_W      = 16,
   parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DFLT,
   localparam int unsigned       AW        = $clog2(DEPTH),
   localparam int unsigned       BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ld_en,
   input  logic [BW-1:0]      i_ld_bank,
   input  logic [AW-1:0]      i_ld_addr,
   input  logic [INSTR_W-1:0] i_ld_data,
   input  logic [BW-1:0]      i_bank_sel,
   input  logic               i_bank_switch,
   input  logic               i_fetch_valid,
   input  logic [PC_W-1:0]    i_fetch_pc,
   output logic               o_fetch_ready,
   output logic               o_instr_valid,
   input  logic               i_instr_ready,
   output logic               o_format,
   output logic [3:0]         o_opcode,
   output logic               o_sign,
   output logic [2:0]         o_operand,
   output logic [7:0]         o_immediate,
   output logic [BW-1:0]      o_active_bank,
   output logic               o_fault,
   output logic               o_halted
);

   logic               r_valid;
   logic               r_fault;
   logic [BW-1:0]      r_bank;
   logic               w_accept;
   logic               w_in_range;
   logic               w_halted;
   logic [INSTR_W-1:0] w_word;
   instr_fields_t      w_fields;

   assign o_fetch_ready = !w_halted && (!r_valid || i_instr_ready);
   assign w_accept      = i_fetch_valid && o_fetch_ready;
   assign w_in_range    = ((i_fetch_pc >> AW) == PC_W'(0));

   // The output word register lives in the RAM read port; halted is its match flag.
   instr_bank_ram #(
      .DEPTH      (DEPTH),
      .BANKS      (BANKS),
      .MATCH_WORD (HALT_WORD)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_we      (i_ld_en),
      .i_wbank   (i_ld_bank),
      .i_waddr   (i_ld_addr),
      .i_wdata   (i_ld_data),
      .i_re      (w_accept),
      .i_rbank   (r_bank),
      .i_raddr   (i_fetch_pc[AW-1:0]),
      .i_rzero   (!w_in_range),
      .i_hit_clr (i_bank_switch),
      .o_rdata   (w_word),
      .o_hit     (w_halted)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_bank  <= '0;
      end else begin
         if (i_bank_switch) begin
            r_bank <= i_bank_sel;
         end
         if (w_accept) begin
            r_valid <= 1'b1;
         end else if (i_instr_ready) begin
            r_valid <= 1'b0;
         end
         if (w_accept && !w_in_range) begin
            r_fault <= 1'b1;
         end
      end
   end

   assign w_fields      = split_instr(w_word);
   assign o_format      = w_fields.format;
   assign o_opcode      = w_fields.opcode;
   assign o_sign        = w_fields.sign;
   assign o_operand     = w_fields.operand;
   assign o_immediate   = w_fields.immediate;
   assign o_instr_valid = r_valid;
   assign o_active_bank = r_bank;
   assign o_fault       = r_fault;
   assign o_halted      = w_halted;

endmodule

// File: tb/tb_instr_fetch_rom.sv
// Directed, table-driven bench for instr_fetch_rom: fetch stream, hold, fault,
// bank switch, read-before-write and reset-with-retention sequences.
module tb_instr_fetch_rom;
   import instr_pkg::*;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned BANKS = 4;
   localparam int unsigned PC_W  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_en;
   logic [1:0]  ld_bank;
   logic [7:0]  ld_addr;
   logic [8:0]  ld_data;
   logic [1:0]  bank_sel;
   logic        bank_switch;
   logic        fetch_valid;
   logic [15:0] fetch_pc;
   logic        fetch_ready;
   logic        instr_valid;
   logic        instr_ready;
   logic        fmt;
   logic [3:0]  opcode;
   logic        sign;
   logic [2:0]  operand;
   logic [7:0]  immediate;
   logic [1:0]  active_bank;
   logic        fault;
   logic        halted;

   always #5 clk = ~clk;

   instr_fetch_rom #(.DEPTH(DEPTH), .BANKS(BANKS), .PC_W(PC_W), .HALT_WORD(9'h1B0)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_ld_en       (ld_en),
      .i_ld_bank     (ld_bank),
      .i_ld_addr     (ld_addr),
      .i_ld_data     (ld_data),
      .i_bank_sel    (bank_sel),
      .i_bank_switch (bank_switch),
      .i_fetch_valid (fetch_valid),
      .i_fetch_pc    (fetch_pc),
      .o_fetch_ready (fetch_ready),
      .o_instr_valid (instr_valid),
      .i_instr_ready (instr_ready),
      .o_format      (fmt),
      .o_opcode      (opcode),
      .o_sign        (sign),
      .o_operand     (operand),
      .o_immediate   (immediate),
      .o_active_bank (active_bank),
      .o_fault       (fault),
      .o_halted      (halted)
   );

   typedef struct {
      logic        fv;
      logic [15:0] pc;
      logic        rdy;
      logic        sw;
      logic [1:0]  sel;
      logic        ld;
      logic [1:0]  lb;
      logic [7:0]  la;
      logic [8:0]  ldat;
      logic        e_ready;
      logic        e_valid;
      logic [8:0]  e_word;
      logic        e_fault;
      logic        e_halt;
      logic [1:0]  e_bank;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic void add(input logic fv, input logic [15:0] pc, input logic rdy,
                               input logic sw, input logic [1:0] sel,
                               input logic ld, input logic [1:0] lb, input logic [7:0] la,
                               input logic [8:0] ldat, input logic er, input logic ev,
                               input logic [8:0] ew, input logic ef, input logic eh,
                               input logic [1:0] eb);
      vec_t v;
      v.fv = fv; v.pc = pc; v.rdy = rdy; v.sw = sw; v.sel = sel;
      v.ld = ld; v.lb = lb; v.la = la; v.ldat = ldat;
      v.e_ready = er; v.e_valid = ev; v.e_word = ew;
      v.e_fault = ef; v.e_halt = eh; v.e_bank = eb;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      fetch_valid = v.fv;  fetch_pc = v.pc;  instr_ready = v.rdy;
      bank_switch = v.sw;  bank_sel = v.sel;
      ld_en = v.ld;  ld_bank = v.lb;  ld_addr = v.la;  ld_data = v.ldat;
   endtask

   // Drive at the falling edge, check fetch_ready before and the registered outputs after the rising edge.
   task automatic apply(input vec_t v, input int idx);
      logic [8:0] ew;
      drive(v);
      #1;
      chk("fetch_ready", idx, 32'(fetch_ready), 32'(v.e_ready));
      @(posedge clk);
      #1;
      ew = v.e_word;
      chk("instr_valid", idx, 32'(instr_valid), 32'(v.e_valid));
      chk("fault", idx, 32'(fault), 32'(v.e_fault));
      chk("halted", idx, 32'(halted), 32'(v.e_halt));
      chk("active_bank", idx, 32'(active_bank), 32'(v.e_bank));
      if (v.e_valid) begin
         chk("word", idx, 32'({fmt, opcode, sign, operand}), 32'(ew));
         chk("immediate", idx, 32'(immediate), 32'(ew[7:0]));
      end
      n_vec++;
      @(negedge clk);
   endtask

   task automatic load(input logic [1:0] b, input logic [7:0] a, input logic [8:0] d);
      ld_en = 1'b1; ld_bank = b; ld_addr = a; ld_data = d;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   initial begin
      logic [8:0] fw [3];
      vec_t       v;
      fw[0] = 9'h042; fw[1] = 9'h123; fw[2] = 9'h0F0;

      rst_n = 1'b0; ld_en = 1'b0; ld_bank = '0; ld_addr = '0; ld_data = '0;
      bank_sel = '0; bank_switch = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
      instr_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", -1, 32'(instr_valid), 32'd0);
      chk("rst_word", -1, 32'({fmt, opcode, sign, operand, immediate}), 32'd0);
      chk("rst_flags", -1, 32'({fault, halted, active_bank}), 32'd0);
      n_vec++;
      @(negedge clk);
      rst_n = 1'b1;

      load(2'd0, 8'd0, 9'h000);
      load(2'd0, 8'd1, 9'h178);
      load(2'd0, 8'd2, 9'h080);
      load(2'd0, 8'd3, 9'h1B0);
      load(2'd0, 8'd5, 9'h0C5);
      load(2'd0, 8'd7, 9'h0AA);
      load(2'd0, 8'd8, 9'h042);
      load(2'd0, 8'd9, 9'h123);
      load(2'd0, 8'd10, 9'h0F0);

      // back-to-back stream ending on the halt word
      add(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h000, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h178, 0, 0, 0);
      add(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h080, 0, 0, 0);
      add(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h1B0, 0, 1, 0);
      add(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 9'h000, 0, 0, 0);
      // 3-cycle hold with a pending request
      add(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'h042, 0, 0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h042, 0, 0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h042, 0, 0, 0);
      add(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h042, 0, 0, 0);
      add(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h123, 0, 0, 0);
      add(1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h0F0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 9'h000, 0, 0, 0);
      // out-of-range PC, then fault must stay set
      add(1, 16'(DEPTH), 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h000, 1, 0, 0);
      for (int k = 0; k < 10; k++) begin
         add(1, 16'(8 + k % 3), 1, 0, 0, 0, 0, 0, 0, 1, 1, fw[k % 3], 1, 0, 0);
      end
      // load and fetch to the same location on one edge
      add(1, 7, 1, 0, 0, 1, 0, 7, 9'h055, 1, 1, 9'h0AA, 1, 0, 0);
      add(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h055, 1, 0, 0);
      // bank switch coinciding with an accept
      add(0, 0, 1, 0, 0, 1, 2, 5, 9'h1F3, 1, 0, 9'h000, 1, 0, 0);
      add(0, 0, 1, 0, 0, 1, 3, 3, 9'h1B0, 1, 0, 9'h000, 1, 0, 0);
      add(1, 5, 1, 1, 2, 0, 0, 0, 0, 1, 1, 9'h0C5, 1, 0, 2);
      add(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9'h1F3, 1, 0, 2);
      add(0, 0, 1, 1, 3, 0, 0, 0, 0, 1, 0, 9'h000, 1, 0, 3);
      add(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'h1B0, 1, 1, 3);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // reset while halted, faulted and holding a valid word
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst2_valid", 100, 32'(instr_valid), 32'd0);
      chk("rst2_word", 100, 32'({fmt, opcode, sign, operand, immediate}), 32'd0);
      chk("rst2_flags", 100, 32'({fault, halted, active_bank}), 32'd0);
      n_vec++;
      @(negedge clk);
      rst_n = 1'b1; fetch_valid = 1'b0; instr_ready = 1'b1;
      #1;
      chk("rst2_ready", 101, 32'(fetch_ready), 32'd1);
      v = '{fv: 1, pc: 16'd1, rdy: 1, sw: 0, sel: 0, ld: 0, lb: 0, la: 0, ldat: 0,
            e_ready: 1, e_valid: 1, e_word: 9'h178, e_fault: 0, e_halt: 0, e_bank: 0};
      apply(v, 102);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
